param_sp_ram: RTL and testbench

PARAM_SP_RAM -- requirements
Module: param_sp_ram

---
 rtl/param_sp_ram.sv | 159 +++++++++++++++
 tb/tb_param_sp_ram.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/param_sp_ram.sv
// Single-port byte-writable RAM with a power-up/clear sweep, selectable
// read-during-write behaviour and an optional output pipeline register.
module param_sp_ram #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  wr,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     data,
  input  logic                  clr,
  output logic [DATA_W-1:0]     out,
  output logic                  out_valid,
  output logic                  ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  function automatic logic [DATA_W-1:0] f_lane_merge(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [NB-1:0]     lane_en
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < NB; i++) begin
      if (lane_en[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [0:0]        r_state;
  logic [ADDR_W:0]   r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_d1;
  logic              r_v1;

  logic              w_acc;
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] w_rd_word;

  // Access qualification and the word a request returns (pre- or post-write).
  always_comb begin
    w_acc     = 1'b0;
    w_old     = r_mem[address];
    w_merged  = w_old;
    w_rd_word = w_old;
    w_acc     = (r_state == ST_RUN) & en & ~clr;
    if (wr) begin
      w_merged = f_lane_merge(w_old, data, be);
    end else begin
      w_merged = w_old;
    end
    if (RDW_MODE == 1) begin
      w_rd_word = w_merged;
    end else begin
      w_rd_word = w_old;
    end
  end

  // Controller: INIT sweeps the array once, RUN serves requests until clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (clr) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
          end else begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Storage array; contents are only ever cleared by the sweep.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_cnt[ADDR_W-1:0]] <= '0;
    end else if (w_acc && wr) begin
      r_mem[address] <= w_merged;
    end
  end

  // First read stage; data holds when no access is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_d1 <= '0;
    end else begin
      r_v1 <= w_acc;
      if (w_acc) begin
        r_d1 <= w_rd_word;
      end
    end
  end

  generate
    if (OUT_REG == 1) begin : g_out_reg
      logic [DATA_W-1:0] r_d2;
      logic              r_v2;

      // Optional output stage; unaffected by clr so in-flight reads drain.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v2 <= 1'b0;
          r_d2 <= '0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) begin
            r_d2 <= r_d1;
          end
        end
      end

      assign out       = r_d2;
      assign out_valid = r_v2;
    end else begin : g_out_direct
      assign out       = r_d1;
      assign out_valid = r_v1;
    end
  endgenerate

  assign ready = (r_state == ST_RUN);

endmodule

// File: tb/tb_param_sp_ram.sv
// Directed bench: default instance (8-bit, old-data, no out reg) alongside a
// 16-bit, new-data, registered-output instance sharing control inputs.
module tb_param_sp_ram;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        wr;
  logic        clr;
  logic [5:0]  address;
  logic [7:0]  data_a;
  logic [0:0]  be_a;
  logic [15:0] data_b;
  logic [1:0]  be_b;
  logic [7:0]  out_a;
  logic [15:0] out_b;
  logic        valid_a;
  logic        valid_b;
  logic        ready_a;
  logic        ready_b;

  int checks;
  int errors;
  int n;

  param_sp_ram u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .wr(wr), .be(be_a),
    .address(address), .data(data_a), .clr(clr),
    .out(out_a), .out_valid(valid_a), .ready(ready_a)
  );

  param_sp_ram #(.DATA_W(16), .ADDR_W(6), .RDW_MODE(1), .OUT_REG(1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .wr(wr), .be(be_b),
    .address(address), .data(data_b), .clr(clr),
    .out(out_b), .out_valid(valid_b), .ready(ready_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    en = 1'b0; wr = 1'b0; clr = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a);
    en = 1'b1; wr = 1'b0; clr = 1'b0; address = a;
  endtask

  task automatic wrt(input logic [5:0] a, input logic [7:0] da, input logic [15:0] db,
                     input logic bea, input logic [1:0] beb);
    en = 1'b1; wr = 1'b1; clr = 1'b0; address = a;
    data_a = da; data_b = db; be_a = bea; be_b = beb;
  endtask

  task automatic wait_ready(input string tag);
    n = 0;
    while (!ready_a && n < 200) begin
      tick();
      n++;
    end
    chk(tag, n, 64);
    chk({tag, "_b"}, ready_b, 1'b1);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; address = 6'd0; data_a = 8'h00; data_b = 16'h0000;
    be_a = 1'b1; be_b = 2'b11;
    idle();
    repeat (3) tick();
    chk("rst_ready_a", ready_a, 1'b0);
    chk("rst_ready_b", ready_b, 1'b0);
    chk("rst_out_a", out_a, 8'h00);
    chk("rst_valid_a", valid_a, 1'b0);
    chk("rst_valid_b", valid_b, 1'b0);

    rst_n = 1'b1;
    wait_ready("init_len");

    for (int i = 0; i < 64; i++) begin
      rd(6'(i));
      tick();
      chk("init_zero_a", out_a, 8'h00);
      chk("init_valid_a", valid_a, 1'b1);
      if (i >= 1) begin
        chk("init_zero_b", out_b, 16'h0000);
        chk("init_valid_b", valid_b, 1'b1);
      end
    end
    idle(); tick();
    chk("idle_valid_a", valid_a, 1'b0);
    chk("tail_valid_b", valid_b, 1'b1);
    tick();
    chk("idle_valid_b", valid_b, 1'b0);

    // Writes return read data too: A old contents, B merged new contents.
    wrt(6'd1, 8'h01, 16'h0101, 1'b1, 2'b11); tick();
    chk("w1_old_a", out_a, 8'h00);
    chk("w1_valid_a", valid_a, 1'b1);
    wrt(6'd0, 8'h03, 16'h0303, 1'b1, 2'b11); tick();
    chk("w0_old_a", out_a, 8'h00);
    chk("w1_new_b", out_b, 16'h0101);
    wrt(6'd3, 8'h02, 16'h0202, 1'b1, 2'b11); tick();
    chk("w0_new_b", out_b, 16'h0303);
    rd(6'd1); tick();
    chk("r1_a", out_a, 8'h01);
    chk("r1_valid_a", valid_a, 1'b1);
    chk("w3_new_b", out_b, 16'h0202);
    rd(6'd3); tick();
    chk("r3_a", out_a, 8'h02);
    chk("r1_b", out_b, 16'h0101);
    chk("r1_valid_b", valid_b, 1'b1);
    rd(6'd0); tick();
    chk("r0_a", out_a, 8'h03);
    chk("r3_b", out_b, 16'h0202);
    chk("r3_valid_b", valid_b, 1'b1);
    idle(); tick();
    chk("hold_valid_a", valid_a, 1'b0);
    chk("hold_out_a", out_a, 8'h03);
    chk("r0_b", out_b, 16'h0303);
    tick();
    chk("hold_valid_b", valid_b, 1'b0);
    chk("hold_out_b", out_b, 16'h0303);

    // Byte-lane merge; be=0 on A leaves memory untouched but still reads.
    wrt(6'd5, 8'hAA, 16'hAAAA, 1'b1, 2'b11); tick();
    wrt(6'd5, 8'h34, 16'h1234, 1'b0, 2'b01); tick();
    chk("be0_old_a", out_a, 8'hAA);
    chk("be0_valid_a", valid_a, 1'b1);
    chk("full_new_b", out_b, 16'hAAAA);
    rd(6'd5); tick();
    chk("be0_keep_a", out_a, 8'hAA);
    chk("merge_rdw_b", out_b, 16'hAA34);
    idle(); tick();
    chk("merge_read_b", out_b, 16'hAA34);

    // Read-during-write on a held word.
    wrt(6'd7, 8'h11, 16'h0011, 1'b1, 2'b11); tick();
    wrt(6'd7, 8'h22, 16'h0022, 1'b1, 2'b11); tick();
    chk("rdw_old_a", out_a, 8'h11);
    idle(); tick();
    chk("rdw_new_b", out_b, 16'h0022);

    // clr with en: request dropped, pipelined read still drains, full sweep.
    rd(6'd3); tick();
    chk("pre_clr_a", out_a, 8'h02);
    wrt(6'd0, 8'hFF, 16'hFFFF, 1'b1, 2'b11);
    clr = 1'b1;
    tick();
    chk("clr_drop_a", valid_a, 1'b0);
    chk("clr_ready_a", ready_a, 1'b0);
    chk("clr_drain_b", out_b, 16'h0202);
    chk("clr_drain_valid_b", valid_b, 1'b1);
    idle();
    n = 0;
    while (!ready_a && n < 200) begin
      if (n == 10) begin
        wrt(6'd2, 8'h77, 16'h7777, 1'b1, 2'b11);
        clr = 1'b1;
      end else begin
        idle();
      end
      tick();
      n++;
      if (n == 11) chk("init_drop_a", valid_a, 1'b0);
    end
    chk("clr_len", n, 64);
    for (int i = 0; i < 64; i++) begin
      rd(6'(i));
      tick();
      chk("clr_zero_a", out_a, 8'h00);
      if (i >= 1) chk("clr_zero_b", out_b, 16'h0000);
    end
    idle(); tick(); tick();

    // Reset mid-sweep restarts the sweep from address 0.
    wrt(6'd9, 8'h55, 16'h0055, 1'b1, 2'b11); tick();
    rd(6'd9); tick();
    chk("r9_a", out_a, 8'h55);
    idle(); tick();
    chk("r9_b", out_b, 16'h0055);
    clr = 1'b1; tick();
    idle();
    repeat (20) tick();
    chk("mid_sweep_ready", ready_a, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_a", out_a, 8'h00);
    chk("async_out_b", out_b, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready("restart_len");
    rd(6'd9); tick();
    chk("r9_cleared_a", out_a, 8'h00);
    idle(); tick();
    chk("r9_cleared_b", out_b, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
